// File: rtl/l3_fifo_reader_if.sv
// rtl/l3_fifo_reader_if.sv - FIFO-side and L3-side signal bundle for l3_fifo_reader
// master is the reader itself; slave is the FIFO/L3 environment around it.
`timescale 1ns/1ps
interface l3_fifo_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 16
);
  logic                           fifo_empty;
  logic                           fifo_batch_ready;
  logic                           fifo_last_batch;
  logic                           fifo_rd_valid;
  logic [CHANNELS*DATA_WIDTH-1:0] fifo_rd_data;
  logic                           fifo_rd_en;
  logic                           out_valid;
  logic                           out_ready;
  logic [CHANNELS*DATA_WIDTH-1:0] out_data;
  logic [3:0]                     out_row;
  logic [3:0]                     out_col;
  logic                           out_batch_end;
  logic                           out_frame_end;

  modport master (
    input  fifo_empty, fifo_batch_ready, fifo_last_batch, fifo_rd_valid, fifo_rd_data,
    output fifo_rd_en,
    output out_valid, out_data, out_row, out_col, out_batch_end, out_frame_end,
    input  out_ready
  );

  modport slave (
    output fifo_empty, fifo_batch_ready, fifo_last_batch, fifo_rd_valid, fifo_rd_data,
    input  fifo_rd_en,
    input  out_valid, out_data, out_row, out_col, out_batch_end, out_frame_end,
    output out_ready
  );
endinterface

// File: rtl/l3_fifo_reader.sv
// rtl/l3_fifo_reader.sv - batch-paced pixel FIFO reader feeding L3
// Reads 28-pixel batches, absorbs the FIFO read latency in a 2-entry buffer, tags row/col/batch/frame.
`timescale 1ns/1ps
module l3_fifo_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int CHANNELS     = 16,
  parameter int BATCH_SIZE   = 28,
  parameter int TOTAL_PIXELS = 196,
  parameter int IMG_W        = 14,
  parameter int BUF_DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  l3_fifo_reader_if.master bus,
  output logic             frame_done,
  output logic             protocol_err
);
  localparam int W      = DATA_WIDTH * CHANNELS;
  localparam int NBATCH = TOTAL_PIXELS / BATCH_SIZE;
  localparam int IW     = $clog2(BATCH_SIZE + 1);
  localparam int QW     = $clog2(BATCH_SIZE);
  localparam int PW     = $clog2(TOTAL_PIXELS);
  localparam int BW     = (NBATCH > 1) ? $clog2(NBATCH) : 1;
  localparam int CW     = $clog2(BUF_DEPTH + 1);
  localparam int AW     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [IW-1:0] ISSUE_MAX  = IW'(BATCH_SIZE);
  localparam logic [IW-1:0] ISSUE_LAST = IW'(BATCH_SIZE - 1);
  localparam logic [QW-1:0] BPOS_LAST  = QW'(BATCH_SIZE - 1);
  localparam logic [PW-1:0] PIX_LAST   = PW'(TOTAL_PIXELS - 1);
  localparam logic [BW-1:0] BATCH_LAST = BW'(NBATCH - 1);
  localparam logic [3:0]    COL_LAST   = 4'(IMG_W - 1);
  localparam logic [CW-1:0] DEPTH      = CW'(BUF_DEPTH);
  localparam logic [AW-1:0] PTR_LAST   = AW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {WAIT_BATCH, READ, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [IW-1:0] issued;
  logic [QW-1:0] bpos;
  logic [PW-1:0] pix;
  logic [BW-1:0] batch_idx;
  logic [3:0]    row, col;
  logic          inflight;
  logic          rd_en, pop, wr_ok, valid, can_read;
  logic [CW-1:0] buf_count;
  logic [CW:0]   used;
  logic [AW-1:0] hd, tl;

  logic [W-1:0] mem_data [BUF_DEPTH];
  logic [3:0]   mem_row  [BUF_DEPTH];
  logic [3:0]   mem_col  [BUF_DEPTH];
  logic         mem_bend [BUF_DEPTH];
  logic         mem_fend [BUF_DEPTH];

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  assign valid = (buf_count != '0);
  assign pop   = valid && bus.out_ready;
  assign wr_ok = bus.fifo_rd_valid && inflight && (buf_count != DEPTH);
  // Credit counts the slot freed by a same-cycle pop so reads sustain one per cycle.
  assign used     = {1'b0, buf_count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign can_read = used < {1'b0, DEPTH};

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      WAIT_BATCH:
        if (en && (bus.fifo_batch_ready || bus.fifo_last_batch) && !bus.fifo_empty)
          state_nxt = READ;
      READ: begin
        rd_en = en && !bus.fifo_empty && can_read && (issued != ISSUE_MAX);
        if (rd_en && issued == ISSUE_LAST) state_nxt = DRAIN;
      end
      DRAIN:
        if (pop && mem_bend[hd]) state_nxt = (batch_idx == BATCH_LAST) ? DONE : WAIT_BATCH;
      DONE:
        state_nxt = WAIT_BATCH;
      default:
        state_nxt = WAIT_BATCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_BATCH;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued       <= '0;
      bpos         <= '0;
      pix          <= '0;
      batch_idx    <= '0;
      row          <= '0;
      col          <= '0;
      inflight     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      inflight <= rd_en ? 1'b1 : (bus.fifo_rd_valid ? 1'b0 : inflight);
      if (bus.fifo_rd_valid && (!inflight || buf_count == DEPTH)) protocol_err <= 1'b1;
      if (state == DONE) begin
        issued    <= '0;
        bpos      <= '0;
        pix       <= '0;
        batch_idx <= '0;
        row       <= '0;
        col       <= '0;
      end else begin
        if (state == WAIT_BATCH && state_nxt == READ) issued <= '0;
        else if (rd_en)                              issued <= issued + IW'(1);
        if (state == DRAIN && state_nxt == WAIT_BATCH) batch_idx <= batch_idx + BW'(1);
        // Tags follow delivered pixels, not issued reads.
        if (wr_ok) begin
          pix  <= pix + PW'(1);
          bpos <= (bpos == BPOS_LAST) ? '0 : bpos + QW'(1);
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 4'd1;
          end else begin
            col <= col + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hd        <= '0;
      tl        <= '0;
      buf_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_row[i]  <= '0;
        mem_col[i]  <= '0;
        mem_bend[i] <= 1'b0;
        mem_fend[i] <= 1'b0;
      end
    end else begin
      if (wr_ok) begin
        mem_data[tl] <= bus.fifo_rd_data;
        mem_row[tl]  <= row;
        mem_col[tl]  <= col;
        mem_bend[tl] <= (bpos == BPOS_LAST);
        mem_fend[tl] <= (pix == PIX_LAST);
        tl           <= next_ptr(tl);
      end
      if (pop) hd <= next_ptr(hd);
      buf_count <= buf_count + CW'(wr_ok) - CW'(pop);
    end
  end

  assign bus.fifo_rd_en    = rd_en;
  assign bus.out_valid     = valid;
  assign bus.out_data      = mem_data[hd];
  assign bus.out_row       = mem_row[hd];
  assign bus.out_col       = mem_col[hd];
  assign bus.out_batch_end = mem_bend[hd];
  assign bus.out_frame_end = mem_fend[hd];
  assign frame_done        = (state == DONE);
endmodule

// File: tb/tb_l3_fifo_reader.sv
// tb/tb_l3_fifo_reader.sv - self-checking bench for l3_fifo_reader
// Behavioural FIFO model with 1-cycle read latency plus a negedge beat monitor.
`timescale 1ns/1ps
module tb_l3_fifo_reader;
  logic clk, rst, en, frame_done, protocol_err;
  l3_fifo_reader_if #(.DATA_WIDTH(8), .CHANNELS(16)) bus ();

  l3_fifo_reader dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus.master),
    .frame_done(frame_done), .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [127:0] mk(input int p);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(p * 3 + k * 29 + 1);
    return r;
  endfunction

  // FIFO model: feed_mode 1 = whole frame at once, 2 = one pixel every 3 cycles.
  int pushed, popped, feed_div;
  logic [1:0] feed_mode;
  logic model_clear, inject;
  assign bus.fifo_empty       = (pushed == popped);
  assign bus.fifo_batch_ready = (pushed - popped) >= 28;
  assign bus.fifo_last_batch  = (pushed == 196);

  always @(posedge clk) begin
    if (model_clear) begin
      pushed <= 0; popped <= 0; feed_div <= 0;
      bus.fifo_rd_valid <= 1'b0; bus.fifo_rd_data <= '0;
    end else begin
      bus.fifo_rd_valid <= 1'b0;
      if (bus.fifo_rd_en && pushed != popped) begin
        bus.fifo_rd_valid <= 1'b1;
        bus.fifo_rd_data  <= mk(popped);
        popped <= popped + 1;
      end
      if (inject) bus.fifo_rd_valid <= 1'b1;
      if (feed_mode == 2'd1) pushed <= 196;
      else if (feed_mode == 2'd2 && pushed < 196) begin
        if (feed_div == 2) begin pushed <= pushed + 1; feed_div <= 0; end
        else feed_div <= feed_div + 1;
      end
    end
  end

  logic mon_clear;
  int nbeat, fd_count, fd_cyc, last_acc, cyc, run, runs, run_bad, early_rd, rd_empty;
  logic seen_ready;
  logic [127:0] beat_data [0:255];
  logic [3:0]   beat_row  [0:255];
  logic [3:0]   beat_col  [0:255];
  logic         beat_bend [0:255];
  logic         beat_fend [0:255];

  always @(negedge clk) begin
    if (mon_clear) begin
      nbeat <= 0; fd_count <= 0; fd_cyc <= 0; last_acc <= 0; cyc <= 0;
      run <= 0; runs <= 0; run_bad <= 0; early_rd <= 0; rd_empty <= 0; seen_ready <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (bus.out_valid && bus.out_ready && nbeat < 256) begin
        beat_data[nbeat] <= bus.out_data;
        beat_row[nbeat]  <= bus.out_row;
        beat_col[nbeat]  <= bus.out_col;
        beat_bend[nbeat] <= bus.out_batch_end;
        beat_fend[nbeat] <= bus.out_frame_end;
        nbeat <= nbeat + 1;
        if (bus.out_frame_end) last_acc <= cyc;
      end
      if (frame_done) begin fd_count <= fd_count + 1; fd_cyc <= cyc; end
      if (bus.fifo_rd_en) run <= run + 1;
      else if (run != 0) begin
        runs <= runs + 1;
        if (run != 28) run_bad <= run_bad + 1;
        run <= 0;
      end
      if (bus.fifo_batch_ready || bus.fifo_last_batch) seen_ready <= 1'b1;
      if (bus.fifo_rd_en && !seen_ready && !(bus.fifo_batch_ready || bus.fifo_last_batch))
        early_rd <= early_rd + 1;
      if (bus.fifo_rd_en && bus.fifo_empty) rd_empty <= rd_empty + 1;
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int order_errs();
    int e = 0;
    for (int i = 0; i < nbeat && i < 256; i++)
      if (beat_data[i] !== mk(i) || beat_row[i] !== 4'(i / 14) || beat_col[i] !== 4'(i % 14)) e++;
    return e;
  endfunction

  task automatic wait_fd(input string name, input int budget);
    int c = 0;
    while (fd_count == 0 && c < budget) begin tick(1); c++; end
    tick(2);
    check({name, "_frame_done_seen"}, fd_count != 0, 1'b1);
  endtask

  task automatic new_frame(input logic [1:0] mode);
    feed_mode = 2'd0; model_clear = 1'b1; mon_clear = 1'b1;
    tick(2);
    model_clear = 1'b0; mon_clear = 1'b0; feed_mode = mode;
  endtask

  typedef struct {
    int beat;
    logic [3:0] row;
    logic [3:0] col;
    logic bend;
    logic fend;
  } vec_t;
  vec_t vecs [9];

  initial begin
    int c, rd_cnt, unstable;
    logic [127:0] held;
    vecs[0] = '{0,   4'd0,  4'd0,  1'b0, 1'b0};
    vecs[1] = '{13,  4'd0,  4'd13, 1'b0, 1'b0};
    vecs[2] = '{14,  4'd1,  4'd0,  1'b0, 1'b0};
    vecs[3] = '{27,  4'd1,  4'd13, 1'b1, 1'b0};
    vecs[4] = '{28,  4'd2,  4'd0,  1'b0, 1'b0};
    vecs[5] = '{55,  4'd3,  4'd13, 1'b1, 1'b0};
    vecs[6] = '{100, 4'd7,  4'd2,  1'b0, 1'b0};
    vecs[7] = '{167, 4'd11, 4'd13, 1'b1, 1'b0};
    vecs[8] = '{195, 4'd13, 4'd13, 1'b1, 1'b1};

    rst = 1'b1; en = 1'b0; bus.out_ready = 1'b0; feed_mode = 2'd0;
    model_clear = 1'b1; mon_clear = 1'b1; inject = 1'b0;
    tick(2);
    check("reset_rd_en", bus.fifo_rd_en, 1'b0);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_out_data", bus.out_data, '0);
    check("reset_tags", {bus.out_row, bus.out_col, bus.out_batch_end, bus.out_frame_end}, '0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_protocol_err", protocol_err, 1'b0);
    rst = 1'b0;

    // Prefilled frame, L3 always ready.
    en = 1'b1; bus.out_ready = 1'b1;
    new_frame(2'd1);
    wait_fd("prefill", 2000);
    check("prefill_beats", nbeat, 196);
    check("prefill_order", order_errs(), 0);
    for (int i = 0; i < 9; i++)
      check($sformatf("tag_beat_%0d", vecs[i].beat),
            {beat_row[vecs[i].beat], beat_col[vecs[i].beat], beat_bend[vecs[i].beat], beat_fend[vecs[i].beat]},
            {vecs[i].row, vecs[i].col, vecs[i].bend, vecs[i].fend});
    check("prefill_read_runs", runs, 7);
    check("prefill_run_len", run_bad, 0);
    check("prefill_frame_done_count", fd_count, 1);
    check("prefill_frame_done_latency", fd_cyc - last_acc, 1);
    check("prefill_err", protocol_err, 1'b0);

    // out_ready low for 10 cycles mid-batch.
    new_frame(2'd1);
    c = 0;
    while (nbeat < 10 && c < 500) begin tick(1); c++; end
    check("stall_reach", nbeat >= 10, 1'b1);
    bus.out_ready = 1'b0;
    #1;
    held = bus.out_data; rd_cnt = 0; unstable = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.fifo_rd_en) rd_cnt++;
      if (bus.out_data !== held || !bus.out_valid) unstable++;
      tick(1);
    end
    check("stall_reads_le2", rd_cnt <= 2, 1'b1);
    check("stall_data_stable", unstable, 0);
    bus.out_ready = 1'b1;
    wait_fd("stall", 2000);
    check("stall_beats", nbeat, 196);
    check("stall_order", order_errs(), 0);
    check("stall_err", protocol_err, 1'b0);

    // Slow producer: one pixel every 3 cycles.
    new_frame(2'd2);
    wait_fd("slow", 3000);
    check("slow_beats", nbeat, 196);
    check("slow_order", order_errs(), 0);
    check("slow_early_read", early_rd, 0);
    check("slow_read_when_empty", rd_empty, 0);

    // en dropped for 5 cycles once pixel 40 has been read.
    new_frame(2'd1);
    c = 0;
    while (popped < 41 && c < 500) begin tick(1); c++; end
    check("en_reach", popped, 41);
    en = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.fifo_rd_en) rd_cnt++;
      tick(1);
    end
    check("en_low_reads", rd_cnt, 0);
    check("en_low_pending_delivered", nbeat, 41);
    en = 1'b1;
    wait_fd("en", 2000);
    check("en_beats", nbeat, 196);
    check("en_order", order_errs(), 0);

    // Reset mid-frame at pixel 100.
    new_frame(2'd1);
    c = 0;
    while (nbeat < 100 && c < 500) begin tick(1); c++; end
    rst = 1'b1;
    #1;
    check("rst_mid_valid", bus.out_valid, 1'b0);
    check("rst_mid_rd_en", bus.fifo_rd_en, 1'b0);
    check("rst_mid_data", bus.out_data, '0);
    check("rst_mid_tags", {bus.out_row, bus.out_col, bus.out_batch_end, bus.out_frame_end}, '0);
    check("rst_mid_no_frame_done", fd_count, 0);
    new_frame(2'd0);
    rst = 1'b0;
    feed_mode = 2'd1;
    c = 0;
    while (nbeat < 1 && c < 100) begin tick(1); c++; end
    check("rst_next_first", {beat_row[0], beat_col[0], beat_data[0] == mk(0)}, {4'd0, 4'd0, 1'b1});
    wait_fd("rst_next", 2000);
    check("rst_next_beats", nbeat, 196);
    check("rst_next_order", order_errs(), 0);

    // Spurious read-valid while idle.
    inject = 1'b1;
    tick(1);
    inject = 1'b0;
    tick(2);
    check("spurious_err_set", protocol_err, 1'b1);
    tick(5);
    check("spurious_err_sticky", protocol_err, 1'b1);
    rst = 1'b1;
    #1;
    check("spurious_err_cleared", protocol_err, 1'b0);
    tick(1);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
